// File: rtl/physical_transmitter_if.sv
// physical_transmitter_if: payload symbol input stream and I/Q sample output stream
interface physical_transmitter_if;
  logic        in_valid;
  logic [1:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready;
  logic        underrun;
  logic        frame_busy;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, underrun, frame_busy
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, underrun, frame_busy
  );
endinterface

// File: rtl/physical_transmitter.sv
// physical_transmitter: QPSK framer, SOF preamble then FRAME_LEN payload symbols, each held SPS samples
module physical_transmitter #(
  parameter int                SPS       = 8,
  parameter int                FRAME_LEN = 63,
  parameter int                GAP_SYMS  = 4,
  parameter logic signed [11:0] AMP      = 12'sd256
) (
  input logic                   clk,
  input logic                   rst_n,
  physical_transmitter_if.slave bus
);
  localparam int SOF_LEN = 26;
  localparam logic [SOF_LEN-1:0] SOF_I = 26'h3278428;
  localparam logic [SOF_LEN-1:0] SOF_Q = 26'h272d17d;
  localparam int SW = $clog2(SPS);
  localparam int CW = $clog2(FRAME_LEN > SOF_LEN ? FRAME_LEN : SOF_LEN);
  localparam int GW = $clog2(GAP_SYMS + 1);
  localparam logic [SW-1:0] SPS_LAST = SW'(SPS - 1);
  localparam logic [CW-1:0] SOF_LAST = CW'(SOF_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(FRAME_LEN - 1);
  localparam logic signed [11:0] NAMP = -AMP;
  typedef enum logic [1:0] {IDLE, SOF, PAYLOAD} state_t;
  state_t            r_state, w_state;
  logic [SW-1:0]     r_sps_cnt;
  logic [CW-1:0]     r_sym_cnt, w_sym_cnt;
  logic [GW-1:0]     r_gap_cnt, w_gap_cnt;
  logic [23:0]       r_out_data, w_out_data;
  logic              r_out_valid, r_underrun, r_frame_busy;
  logic              w_beat, w_boundary, w_load;
  logic [SOF_LEN-1:0] w_sof_i, w_sof_q;
  logic [1:0]        w_pay;
  always_comb begin
    w_beat     = r_out_valid & bus.out_ready;
    w_boundary = w_beat & (r_sps_cnt == SPS_LAST);
    w_load     = w_boundary & ((r_state == SOF & r_sym_cnt == SOF_LAST) |
                               (r_state == PAYLOAD & r_sym_cnt < PAY_LAST));
    w_state    = r_state;
    w_sym_cnt  = r_sym_cnt;
    w_gap_cnt  = r_gap_cnt;
    w_out_data = r_out_data;
    if (w_boundary)
      case (r_state)
        SOF: begin
          w_state   = r_sym_cnt == SOF_LAST ? PAYLOAD : SOF;
          w_sym_cnt = r_sym_cnt == SOF_LAST ? '0 : r_sym_cnt + 1'b1;
        end
        PAYLOAD: begin
          w_state   = r_sym_cnt == PAY_LAST ? IDLE : PAYLOAD;
          w_sym_cnt = r_sym_cnt + 1'b1;
          w_gap_cnt = GW'(GAP_SYMS - 1);
        end
        default: begin
          w_state   = r_gap_cnt == '0 && bus.in_valid ? SOF : IDLE;
          w_sym_cnt = '0;
          w_gap_cnt = r_gap_cnt == '0 ? r_gap_cnt : r_gap_cnt - 1'b1;
        end
      endcase
    // preamble bits are sent MSB first, so shift the next symbol's bit into the top position
    w_sof_i = SOF_I << w_sym_cnt;
    w_sof_q = SOF_Q << w_sym_cnt;
    w_pay   = bus.in_valid ? bus.in_data : 2'b00;
    if (w_boundary)
      w_out_data = w_state == IDLE ? 24'd0 :
                   w_state == SOF  ? {w_sof_i[SOF_LEN-1] ? AMP : NAMP, w_sof_q[SOF_LEN-1] ? AMP : NAMP} :
                                     {w_pay[1] ? NAMP : AMP, w_pay[0] ? NAMP : AMP};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sps_cnt    <= '0;
      r_sym_cnt    <= '0;
      r_gap_cnt    <= GW'(GAP_SYMS);
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_busy <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sym_cnt    <= w_sym_cnt;
      r_gap_cnt    <= w_gap_cnt;
      r_out_data   <= w_out_data;
      r_out_valid  <= 1'b1;
      r_underrun   <= w_load & ~bus.in_valid;
      r_frame_busy <= w_state != IDLE;
      if (w_beat) r_sps_cnt <= r_sps_cnt == SPS_LAST ? '0 : r_sps_cnt + 1'b1;
    end
  assign bus.in_ready   = w_load;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.underrun   = r_underrun;
  assign bus.frame_busy = r_frame_busy;
endmodule
